// File: rtl/cfi_ctrl_seq_if.sv
// Request/response and engine-strobe bundle for cfi_ctrl_seq.
// Latency: none, wires only. Signal suffixes are from the sequencer's point of view.
// Backpressure: req_valid_i/req_ready_o handshake, single response pulse, no credits.
interface cfi_ctrl_seq_if;
    // system-side request/response
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [23:0] req_adr_i;
    logic [15:0] req_dat_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_dat_o;
    logic [7:0]  rsp_status_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    // engine side
    logic        eng_do_rst_o;
    logic        eng_do_readstatus_o;
    logic        eng_do_clearstatus_o;
    logic        eng_do_eraseblock_o;
    logic        eng_do_unlockblock_o;
    logic        eng_do_write_o;
    logic        eng_do_read_o;
    logic [23:0] eng_adr_o;
    logic [15:0] eng_dat_o;
    logic [15:0] eng_dat_i;
    logic        eng_done_i;
    logic        eng_busy_i;

    // sequencer view
    modport slave (
        input  req_valid_i, req_op_i, req_adr_i, req_dat_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_err_o, rsp_timeout_o,
        output eng_do_rst_o, eng_do_readstatus_o, eng_do_clearstatus_o, eng_do_eraseblock_o,
        output eng_do_unlockblock_o, eng_do_write_o, eng_do_read_o, eng_adr_o, eng_dat_o,
        input  eng_dat_i, eng_done_i, eng_busy_i
    );

    // requester + engine view
    modport master (
        output req_valid_i, req_op_i, req_adr_i, req_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_err_o, rsp_timeout_o,
        input  eng_do_rst_o, eng_do_readstatus_o, eng_do_clearstatus_o, eng_do_eraseblock_o,
        input  eng_do_unlockblock_o, eng_do_write_o, eng_do_read_o, eng_adr_o, eng_dat_o,
        output eng_dat_i, eng_done_i, eng_busy_i
    );
endinterface

// File: rtl/cfi_ctrl_seq.sv
// Purpose: turns one read/program/erase/reset request into the cfi_ctrl_engine strobe sequence
//          (unlock, erase/write, status polling, error check, clear on error).
// Latency: op-dependent, bounded by POLL_MAX status reads; one request in flight, excess requests ignored.
// Optional: CFI_SEQ_VERIFY_EN adds a read-back compare after a successful program.
module cfi_ctrl_seq #(
    parameter int unsigned POLL_MAX = 4096,
    parameter int unsigned POLL_GAP = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    cfi_ctrl_seq_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ARM, ST_WAIT_BUSY, ST_STAT_REQ, ST_STAT_WAIT,
        ST_STAT_DRAIN, ST_GAP, ST_RESP, ST_RESP_END
    } state_t;

    // which engine command is currently outstanding; selects the follow-up action
    typedef enum logic [2:0] {
        STEP_READ, STEP_RST, STEP_WRITE, STEP_UNLOCK, STEP_ERASE, STEP_CLEAR, STEP_VREAD
    } step_t;

    // strobe bit positions; one vector register makes the one-hot property structural
    localparam int SB_RST   = 0;
    localparam int SB_RSTAT = 1;
    localparam int SB_CLR   = 2;
    localparam int SB_ERASE = 3;
    localparam int SB_UNLK  = 4;
    localparam int SB_WRITE = 5;
    localparam int SB_READ  = 6;

    state_t      state_q;
    step_t       step_q;
    logic [6:0]  strb_q;
    logic        arm_cnt_q;
    logic [15:0] poll_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic        req_ready_q;
    logic [23:0] adr_q;
    logic [15:0] wdat_q;
    // working result, copied into the rsp_* registers only when the response fires
    logic [15:0] w_dat_q;
    logic [7:0]  w_status_q;
    logic        w_err_q;
    logic        w_to_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_dat_q;
    logic [7:0]  rsp_status_q;
    logic        rsp_err_q;
    logic        rsp_timeout_q;

    // error bits that matter depend on which command was being polled
    function automatic logic stat_err(input step_t s, input logic [7:0] st);
        case (s)
            STEP_WRITE:  stat_err = st[4] | st[3];
            STEP_ERASE:  stat_err = st[5] | st[3];
            STEP_UNLOCK: stat_err = st[5] | st[4] | st[3];
            default:     stat_err = 1'b0;
        endcase
    endfunction

    // sequencer FSM; every output is a register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_RST;
            strb_q        <= '0;
            arm_cnt_q     <= 1'b0;
            poll_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            req_ready_q   <= 1'b1;
            adr_q         <= '0;
            wdat_q        <= '0;
            w_dat_q       <= '0;
            w_status_q    <= '0;
            w_err_q       <= 1'b0;
            w_to_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_status_q  <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-issued below
            strb_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        req_ready_q <= 1'b0;
                        adr_q       <= bus.req_adr_i;
                        wdat_q      <= bus.req_dat_i;
                        w_dat_q     <= '0;
                        w_status_q  <= '0;
                        w_err_q     <= 1'b0;
                        w_to_q      <= 1'b0;
                        arm_cnt_q   <= 1'b0;
                        state_q     <= ST_ARM;
                        case (bus.req_op_i)
                            2'b00: begin strb_q[SB_READ]  <= 1'b1; step_q <= STEP_READ;   end
                            2'b01: begin strb_q[SB_WRITE] <= 1'b1; step_q <= STEP_WRITE;  end
                            2'b10: begin strb_q[SB_UNLK]  <= 1'b1; step_q <= STEP_UNLOCK; end
                            default: begin strb_q[SB_RST] <= 1'b1; step_q <= STEP_RST;    end
                        endcase
                    end
                end
                // two cycles of blind wait so the engine has raised busy before we look at it
                ST_ARM: begin
                    if (arm_cnt_q) state_q <= ST_WAIT_BUSY;
                    else           arm_cnt_q <= 1'b1;
                end
                ST_WAIT_BUSY: begin
                    if (!bus.eng_busy_i) begin
                        case (step_q)
                            STEP_READ: begin
                                w_dat_q <= bus.eng_dat_i;
                                state_q <= ST_RESP;
                            end
                            STEP_VREAD: begin
                                w_dat_q <= bus.eng_dat_i;
                                if (bus.eng_dat_i != wdat_q) w_err_q <= 1'b1;
                                state_q <= ST_RESP;
                            end
                            STEP_WRITE, STEP_UNLOCK, STEP_ERASE: begin
                                poll_cnt_q <= '0;
                                state_q    <= ST_STAT_REQ;
                            end
                            default: state_q <= ST_RESP;
                        endcase
                    end
                end
                ST_STAT_REQ: begin
                    strb_q[SB_RSTAT] <= 1'b1;
                    poll_cnt_q       <= poll_cnt_q + 16'd1;
                    state_q          <= ST_STAT_WAIT;
                end
                ST_STAT_WAIT: begin
                    if (bus.eng_done_i) begin
                        w_status_q <= bus.eng_dat_i[7:0];
                        state_q    <= ST_STAT_DRAIN;
                    end
                end
                ST_STAT_DRAIN: begin
                    if (!bus.eng_busy_i) begin
                        arm_cnt_q <= 1'b0;
                        if (w_status_q[7]) begin
                            if (stat_err(step_q, w_status_q)) begin
                                w_err_q        <= 1'b1;
                                strb_q[SB_CLR] <= 1'b1;
                                step_q         <= STEP_CLEAR;
                                state_q        <= ST_ARM;
                            end else if (step_q == STEP_UNLOCK) begin
                                strb_q[SB_ERASE] <= 1'b1;
                                step_q           <= STEP_ERASE;
                                state_q          <= ST_ARM;
`ifdef CFI_SEQ_VERIFY_EN
                            end else if (step_q == STEP_WRITE) begin
                                strb_q[SB_READ] <= 1'b1;
                                step_q          <= STEP_VREAD;
                                state_q         <= ST_ARM;
`endif
                            end else begin
                                state_q <= ST_RESP;
                            end
                        end else if (poll_cnt_q == 16'(POLL_MAX)) begin
                            // device never reported ready: flag and clear whatever it latched
                            w_err_q        <= 1'b1;
                            w_to_q         <= 1'b1;
                            strb_q[SB_CLR] <= 1'b1;
                            step_q         <= STEP_CLEAR;
                            state_q        <= ST_ARM;
                        end else if (POLL_GAP == 0) begin
                            state_q <= ST_STAT_REQ;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'(POLL_GAP - 1)) state_q <= ST_STAT_REQ;
                    else                               gap_cnt_q <= gap_cnt_q + 8'd1;
                end
                // publish the result; rsp_* stays put until the next response
                ST_RESP: begin
                    rsp_valid_q   <= 1'b1;
                    rsp_dat_q     <= w_dat_q;
                    rsp_status_q  <= w_status_q;
                    rsp_err_q     <= w_err_q;
                    rsp_timeout_q <= w_to_q;
                    state_q       <= ST_RESP_END;
                end
                ST_RESP_END: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o          = req_ready_q;
    assign bus.rsp_valid_o          = rsp_valid_q;
    assign bus.rsp_dat_o            = rsp_dat_q;
    assign bus.rsp_status_o         = rsp_status_q;
    assign bus.rsp_err_o            = rsp_err_q;
    assign bus.rsp_timeout_o        = rsp_timeout_q;
    assign bus.eng_do_rst_o         = strb_q[SB_RST];
    assign bus.eng_do_readstatus_o  = strb_q[SB_RSTAT];
    assign bus.eng_do_clearstatus_o = strb_q[SB_CLR];
    assign bus.eng_do_eraseblock_o  = strb_q[SB_ERASE];
    assign bus.eng_do_unlockblock_o = strb_q[SB_UNLK];
    assign bus.eng_do_write_o       = strb_q[SB_WRITE];
    assign bus.eng_do_read_o        = strb_q[SB_READ];
    assign bus.eng_adr_o            = adr_q;
    assign bus.eng_dat_o            = wdat_q;

endmodule

// File: tb/tb_cfi_ctrl_seq.sv
// Directed bench for cfi_ctrl_seq with a small behavioural engine model.
// Engine: strobe seen -> busy for 3 cycles, done on the last busy cycle with data.
// Strobes are logged as hex nibbles: 1 rst, 2 readstatus, 3 clear, 4 erase, 5 unlock, 6 write, 7 read.
module tb_cfi_ctrl_seq;
    localparam int POLL_MAX = 4;
    localparam int POLL_GAP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfi_ctrl_seq_if bus();

    cfi_ctrl_seq #(.POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // engine model + strobe monitor, all at the falling edge
    logic [7:0]  stq[$];
    logic [15:0] rd_val = 16'h0;
    logic [15:0] pend;
    int          eng_cnt = 0;
    logic [31:0] seq = 0;
    int          ncyc = 0;
    int          rs_cyc[8];
    int          rs_n = 0;
    int          acc_n = 0;
    int          onehot_bad = 0;

    initial begin
        logic [6:0] s;
        logic [3:0] code;
        bus.eng_busy_i = 1'b0;
        bus.eng_done_i = 1'b0;
        bus.eng_dat_i  = 16'h0;
        pend = 16'h0;
        forever begin
            @(negedge clk);
            ncyc++;
            s = {bus.eng_do_read_o, bus.eng_do_write_o, bus.eng_do_unlockblock_o,
                 bus.eng_do_eraseblock_o, bus.eng_do_clearstatus_o,
                 bus.eng_do_readstatus_o, bus.eng_do_rst_o};
            if (bus.req_valid_i && bus.req_ready_o) acc_n++;
            if ($countones(s) > 1) onehot_bad++;
            if (bus.eng_done_i) begin
                bus.eng_done_i = 1'b0;
                bus.eng_busy_i = 1'b0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_done_i = 1'b1;
                    bus.eng_dat_i  = pend;
                end
            end
            if (s != 7'd0) begin
                code = 4'd0;
                for (int b = 0; b < 7; b++) if (s[b]) code = 4'(b + 1);
                seq = (seq << 4) | 32'(code);
                if (s[1]) begin
                    if (rs_n < 8) rs_cyc[rs_n] = ncyc;
                    rs_n++;
                    pend = (stq.size() > 0) ? {8'h00, stq.pop_front()} : 16'h0000;
                end else if (s[6]) begin
                    pend = rd_val;
                end else begin
                    pend = 16'h0000;
                end
                bus.eng_busy_i = 1'b1;
                eng_cnt = 2;
            end
        end
    end

    logic [15:0] r_dat;
    logic [7:0]  r_status;
    logic        r_err, r_to;

    task automatic run_op(input logic [1:0] op, input logic [23:0] adr, input logic [15:0] dat,
                          input bit hold);
        bit got;
        seq = 0; rs_n = 0; acc_n = 0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_adr_i   = adr;
        bus.req_dat_i   = dat;
        if (!hold) begin
            @(posedge clk); #1;
            bus.req_valid_i = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) got = 1'b1;
        end
        bus.req_valid_i = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        r_dat = bus.rsp_dat_o; r_status = bus.rsp_status_o;
        r_err = bus.rsp_err_o; r_to = bus.rsp_timeout_o;
        chk("ready_low_at_rsp", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        chk("ready_back", 32'(bus.req_ready_o), 32'd1);
        chk("rsp_one_cycle", 32'(bus.rsp_valid_o), 32'd0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 2'b00;
        bus.req_adr_i   = 24'h0;
        bus.req_dat_i   = 16'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_strobes", 32'({bus.eng_do_rst_o, bus.eng_do_readstatus_o, bus.eng_do_clearstatus_o,
            bus.eng_do_eraseblock_o, bus.eng_do_unlockblock_o, bus.eng_do_write_o, bus.eng_do_read_o}), 32'd0);
        chk("rst_eng_adr", 32'(bus.eng_adr_o), 32'd0);
        rst_n = 1'b1;

        // flash reset
        run_op(2'b11, 24'h0, 16'h0, 1'b0);
        chk("rst_seq", seq, 32'h1);
        chk("rst_err", 32'(r_err), 32'd0);
        chk("rst_status", 32'(r_status), 32'h00);

        // erase: unlock poll ready, then two not-ready erase polls and a ready one
        stq = '{8'h80, 8'h00, 8'h00, 8'h80};
        run_op(2'b10, 24'h001000, 16'h0, 1'b0);
        chk("erase_seq", seq, 32'h524222);
        chk("erase_err", 32'(r_err), 32'd0);
        chk("erase_status", 32'(r_status), 32'h80);
        chk("erase_adr", 32'(bus.eng_adr_o), 32'h001000);
        // pulse at k: wait k..k+2, drain k+3, gap k+4..k+6, req k+7, next pulse k+8
        chk("poll_gap_1", 32'(rs_cyc[2] - rs_cyc[1]), 32'(POLL_GAP + 5));
        chk("poll_gap_2", 32'(rs_cyc[3] - rs_cyc[2]), 32'(POLL_GAP + 5));

        // program with error status
        stq = '{8'h90};
        run_op(2'b01, 24'h001001, 16'hCAFE, 1'b0);
        chk("pgm_err_seq", seq, 32'h623);
        chk("pgm_err_err", 32'(r_err), 32'd1);
        chk("pgm_err_to", 32'(r_to), 32'd0);
        chk("pgm_err_status", 32'(r_status), 32'h90);
        chk("pgm_wdat", 32'(bus.eng_dat_o), 32'hCAFE);

        // program that never becomes ready: POLL_MAX status reads then clear
        stq = {};
        run_op(2'b01, 24'h001002, 16'h1234, 1'b0);
        chk("to_seq", seq, 32'h622223);
        chk("to_rs_count", 32'(rs_n), 32'(POLL_MAX));
        chk("to_timeout", 32'(r_to), 32'd1);
        chk("to_err", 32'(r_err), 32'd1);

        // read with request held valid throughout
        rd_val = 16'hDEAD;
        run_op(2'b00, 24'h001000, 16'h0, 1'b1);
        chk("rd_seq", seq, 32'h7);
        chk("rd_dat", 32'(r_dat), 32'hDEAD);
        chk("rd_accepts", 32'(acc_n), 32'd1);
        chk("rd_status", 32'(r_status), 32'h00);
        chk("rd_timeout_clr", 32'(r_to), 32'd0);

        // unlock failure aborts erase
        stq = '{8'hA0};
        run_op(2'b10, 24'h002000, 16'h0, 1'b0);
        chk("unlk_err_seq", seq, 32'h523);
        chk("unlk_err_err", 32'(r_err), 32'd1);
        chk("unlk_err_status", 32'(r_status), 32'hA0);

        // successful program
        stq = '{8'h80};
        rd_val = 16'hC000;
        run_op(2'b01, 24'h003000, 16'hC001, 1'b0);
`ifdef CFI_SEQ_VERIFY_EN
        chk("vfy_bad_seq", seq, 32'h627);
        chk("vfy_bad_err", 32'(r_err), 32'd1);
        chk("vfy_bad_dat", 32'(r_dat), 32'hC000);
        stq = '{8'h80};
        rd_val = 16'hC001;
        run_op(2'b01, 24'h003000, 16'hC001, 1'b0);
        chk("vfy_ok_seq", seq, 32'h627);
        chk("vfy_ok_err", 32'(r_err), 32'd0);
        chk("vfy_ok_dat", 32'(r_dat), 32'hC001);
`else
        chk("pgm_ok_seq", seq, 32'h62);
        chk("pgm_ok_err", 32'(r_err), 32'd0);
        chk("pgm_ok_dat", 32'(r_dat), 32'h0000);
`endif
        chk("pgm_ok_status", 32'(r_status), 32'h80);

        // response fields stay put while idle
        repeat (5) @(negedge clk);
        chk("rsp_hold_status", 32'(bus.rsp_status_o), 32'h80);
        chk("rsp_hold_dat", 32'(bus.rsp_dat_o), 32'(r_dat));

        // asynchronous reset while the unlock strobe is high
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 2'b10;
        bus.req_adr_i   = 24'h004000;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        chk("arst_pre_strobe", 32'(bus.eng_do_unlockblock_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_strobe_drop", 32'(bus.eng_do_unlockblock_o), 32'd0);
        chk("arst_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_op(2'b11, 24'h0, 16'h0, 1'b0);
        chk("arst_recover_seq", seq, 32'h1);

        chk("strobe_onehot", 32'(onehot_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
